// File: rtl/filter_mavg_pkg.sv
// Shared types, width helpers, scale constant and saturation for the multi-channel moving average.
package filter_mavg_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StAcc,
      StMult
   } state_e;

   function automatic int unsigned sum_width(input int unsigned data_w, input int unsigned length);
      return data_w + $clog2(length);
   endfunction

   function automatic int unsigned prod_width(input int unsigned data_w, input int unsigned length,
                                              input int unsigned weight_w);
      return sum_width(data_w, length) + weight_w + 1;
   endfunction

   // round(2^weight_w / length), half rounded up.
   function automatic longint unsigned scale_val(input int unsigned length,
                                                 input int unsigned weight_w);
      longint unsigned num;
      num = 64'd1 << weight_w;
      return (64'd2 * num + 64'(length)) / (64'd2 * 64'(length));
   endfunction

   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                     input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi) begin
         return hi;
      end
      if (x < lo) begin
         return lo;
      end
      return x;
   endfunction

endpackage

// File: rtl/mavg_delay_ram.sv
// 1R1W synchronous delay-line RAM with one cycle of read latency; contents are never cleared.
module mavg_delay_ram #(
   parameter int unsigned DEPTH = 128,
   parameter int unsigned WIDTH = 16,
   localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              i_clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]  i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [WIDTH-1:0]  o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
      if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/filter_mavg_multich.sv
// Time-multiplexed moving-average filter, one running sum per channel, 4 cycles per sample.
// Define FILTER_MAVG_MULTICH_EXT_MULT_EN to route the scaling multiply to an external multiplier.
module filter_mavg_multich
   import filter_mavg_pkg::*;
#(
   parameter int unsigned BITWIDTH_DATA   = 16,
   parameter int unsigned LENGTH          = 32,
   parameter int unsigned NUM_CHANNELS    = 4,
   parameter bit          UINT_IO         = 1'b0,
   parameter int unsigned BITWIDTH_WEIGHT = 16,
   localparam int unsigned CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
   localparam int unsigned SUM_W  = sum_width(BITWIDTH_DATA, LENGTH),
   localparam int unsigned PROD_W = prod_width(BITWIDTH_DATA, LENGTH, BITWIDTH_WEIGHT)
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       IN_VALID,
   output logic                       IN_READY,
   input  logic [BITWIDTH_DATA-1:0]   DATA_IN,
   input  logic [CH_W-1:0]            CH_IN,
   output logic [BITWIDTH_DATA-1:0]   DATA_OUT,
   output logic [CH_W-1:0]            CH_OUT,
   output logic                       DATA_VALID
`ifdef FILTER_MAVG_MULTICH_EXT_MULT_EN
   ,
   output logic [SUM_W-1:0]           MULT_INA,
   output logic [BITWIDTH_WEIGHT-1:0] MULT_INB,
   input  logic [PROD_W-1:0]          MULT_OUT
`endif
);

   localparam int unsigned PTR_W  = $clog2(LENGTH);
   localparam int unsigned FILL_W = $clog2(LENGTH + 1);
   localparam int unsigned DEPTH  = NUM_CHANNELS * LENGTH;
   localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [BITWIDTH_WEIGHT-1:0] SCALE =
      BITWIDTH_WEIGHT'(scale_val(LENGTH, BITWIDTH_WEIGHT));
   localparam logic [BITWIDTH_DATA-1:0] MSB_FLIP = {UINT_IO, {(BITWIDTH_DATA - 1){1'b0}}};
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LENGTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LENGTH - 1);
   localparam logic signed [PROD_W-1:0] ROUND_HALF = PROD_W'(1) <<< (BITWIDTH_WEIGHT - 1);

   state_e                          r_state;
   logic signed [BITWIDTH_DATA-1:0] r_sample;
   logic [CH_W-1:0]                 r_ch;
   logic signed [SUM_W-1:0]         r_sum  [NUM_CHANNELS];
   logic [PTR_W-1:0]                r_ptr  [NUM_CHANNELS];
   logic [FILL_W-1:0]               r_fill [NUM_CHANNELS];
   logic [BITWIDTH_DATA-1:0]        r_data_out;
   logic [CH_W-1:0]                 r_ch_out;
   logic                            r_data_valid;

   logic                            w_accept;
   logic                            w_ch_ok;
   logic [ADDR_W-1:0]               w_addr;
   logic [BITWIDTH_DATA-1:0]        w_ram_rd;
   logic signed [BITWIDTH_DATA-1:0] w_oldest;
   logic signed [SUM_W-1:0]         w_sum_cur;
   logic signed [SUM_W-1:0]         w_sum_next;
   logic signed [PROD_W-1:0]        w_prod;
   logic signed [PROD_W-1:0]        w_round;
   logic signed [PROD_W-1:0]        w_shift;
   logic [BITWIDTH_DATA-1:0]        w_result;

   assign IN_READY   = (r_state == StIdle) && !RST;
   assign w_accept   = IN_VALID && IN_READY;
   assign w_ch_ok    = 32'(CH_IN) < NUM_CHANNELS;
   assign w_sum_cur  = r_sum[r_ch];
   assign w_addr     = ADDR_W'(r_ch) * ADDR_W'(LENGTH) + ADDR_W'(r_ptr[r_ch]);

   // Slots not yet written since reset hold stale data; treat them as zero.
   assign w_oldest   = (r_fill[r_ch] < FILL_FULL) ? '0 : w_ram_rd;
   assign w_sum_next = w_sum_cur + SUM_W'(r_sample) - SUM_W'(w_oldest);

   mavg_delay_ram #(
      .DEPTH (DEPTH),
      .WIDTH (BITWIDTH_DATA)
   ) u_delay_ram (
      .i_clk     (CLK),
      .i_wr_en   (r_state == StAcc),
      .i_wr_addr (w_addr),
      .i_wr_data (r_sample),
      .i_rd_en   (r_state == StRead),
      .i_rd_addr (w_addr),
      .o_rd_data (w_ram_rd)
   );

`ifdef FILTER_MAVG_MULTICH_EXT_MULT_EN
   assign MULT_INA = (r_state == StMult) ? w_sum_cur : '0;
   assign MULT_INB = (r_state == StMult) ? SCALE : '0;
   assign w_prod   = MULT_OUT;
`else
   logic signed [PROD_W-1:0] w_mult_a;
   logic signed [PROD_W-1:0] w_mult_b;

   assign w_mult_a = PROD_W'(w_sum_cur);
   assign w_mult_b = PROD_W'(SCALE);
   assign w_prod   = w_mult_a * w_mult_b;
`endif

   assign w_round  = w_prod + ROUND_HALF;
   assign w_shift  = w_round >>> BITWIDTH_WEIGHT;
   assign w_result = BITWIDTH_DATA'(sat_signed(64'(w_shift), BITWIDTH_DATA));

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= StIdle;
         r_sample     <= '0;
         r_ch         <= '0;
         r_data_out   <= '0;
         r_ch_out     <= '0;
         r_data_valid <= 1'b0;
         for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            r_sum[i]  <= '0;
            r_ptr[i]  <= '0;
            r_fill[i] <= '0;
         end
      end else begin
         r_data_valid <= 1'b0;
         case (r_state)
            StIdle: begin
               // Out-of-range channels are consumed and silently dropped.
               if (w_accept && w_ch_ok) begin
                  r_sample <= DATA_IN ^ MSB_FLIP;
                  r_ch     <= CH_IN;
                  r_state  <= StRead;
               end
            end
            StRead: begin
               r_state <= StAcc;
            end
            StAcc: begin
               r_sum[r_ch] <= w_sum_next;
               r_ptr[r_ch] <= (r_ptr[r_ch] == PTR_LAST) ? '0 : r_ptr[r_ch] + PTR_W'(1);
               if (r_fill[r_ch] < FILL_FULL) begin
                  r_fill[r_ch] <= r_fill[r_ch] + FILL_W'(1);
               end
               r_state <= StMult;
            end
            StMult: begin
               r_data_out   <= w_result ^ MSB_FLIP;
               r_ch_out     <= r_ch;
               r_data_valid <= 1'b1;
               r_state      <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign DATA_OUT   = r_data_out;
   assign CH_OUT     = r_ch_out;
   assign DATA_VALID = r_data_valid;

endmodule

// File: tb/tb_filter_mavg_multich.sv
// Self-checking bench: three filter instances (signed L=4, offset-binary L=4, signed L=6 x3 ch).
module tb_filter_mavg_multich;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid   [3];
   logic [7:0] data_in    [3];
   logic [1:0] ch_in      [3];
   logic       in_ready   [3];
   logic       data_valid [3];
   logic [7:0] data_out   [3];
   logic [1:0] ch_out     [3];
   logic       co0;
   logic       co1;
   logic [1:0] co2;

   int total = 0;
   int bad   = 0;

   // Accepted-sample history of every instance, in acceptance order (internal signed domain).
   int h_d[$];
   int h_ch[$];
   int h_v[$];

   always #5 clk = ~clk;

   assign ch_out[0] = {1'b0, co0};
   assign ch_out[1] = {1'b0, co1};
   assign ch_out[2] = co2;

   filter_mavg_multich #(
      .BITWIDTH_DATA (8), .LENGTH (4), .NUM_CHANNELS (2), .UINT_IO (1'b0), .BITWIDTH_WEIGHT (8)
   ) u_dut (
      .CLK (clk), .RST (rst), .IN_VALID (in_valid[0]), .IN_READY (in_ready[0]),
      .DATA_IN (data_in[0]), .CH_IN (ch_in[0][0]), .DATA_OUT (data_out[0]), .CH_OUT (co0),
      .DATA_VALID (data_valid[0])
   );

   filter_mavg_multich #(
      .BITWIDTH_DATA (8), .LENGTH (4), .NUM_CHANNELS (2), .UINT_IO (1'b1), .BITWIDTH_WEIGHT (8)
   ) u_dut_uint (
      .CLK (clk), .RST (rst), .IN_VALID (in_valid[1]), .IN_READY (in_ready[1]),
      .DATA_IN (data_in[1]), .CH_IN (ch_in[1][0]), .DATA_OUT (data_out[1]), .CH_OUT (co1),
      .DATA_VALID (data_valid[1])
   );

   // LENGTH=6 gives SCALE=43 (> 256/6), so full-scale streams really do clip.
   filter_mavg_multich #(
      .BITWIDTH_DATA (8), .LENGTH (6), .NUM_CHANNELS (3), .UINT_IO (1'b0), .BITWIDTH_WEIGHT (8)
   ) u_dut_sat (
      .CLK (clk), .RST (rst), .IN_VALID (in_valid[2]), .IN_READY (in_ready[2]),
      .DATA_IN (data_in[2]), .CH_IN (ch_in[2]), .DATA_OUT (data_out[2]), .CH_OUT (co2),
      .DATA_VALID (data_valid[2])
   );

   function automatic int num_ch(input int d);
      return (d == 2) ? 3 : 2;
   endfunction

   function automatic void hist_push(input int d, input int ch, input int val);
      h_d.push_back(d);
      h_ch.push_back(ch);
      h_v.push_back((d == 1) ? val - 128 : val);
   endfunction

   function automatic void hist_clear();
      h_d.delete();
      h_ch.delete();
      h_v.delete();
   endfunction

   // Zero-padded window average: sum of last LENGTH samples of the channel times round(256/L),
   // rounded half up by 8 bits, clipped to 8-bit signed, offset back for the unsigned instance.
   function automatic int model(input int d, input int ch);
      int len, scale, sum, cnt, r;
      len   = (d == 2) ? 6 : 4;
      scale = (512 + len) / (2 * len);
      sum   = 0;
      cnt   = 0;
      for (int i = h_d.size() - 1; i >= 0; i--) begin
         if (cnt < len && h_d[i] == d && h_ch[i] == ch) begin
            sum += h_v[i];
            cnt++;
         end
      end
      r = (sum * scale + 128) >>> 8;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      return (d == 1) ? r + 128 : r;
   endfunction

   function automatic int out_val(input int d);
      return (d == 1) ? int'(data_out[d]) : int'($signed(data_out[d]));
   endfunction

   // Called and returning in the phase #1 after a rising edge.
   task automatic send(input int d, input int ch, input int val,
                       output int res, output int rch, output int lat);
      int guard;
      guard = 0;
      res   = 0;
      rch   = -1;
      lat   = -1;
      while (!in_ready[d] && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      in_valid[d] = 1'b1;
      data_in[d]  = 8'(val);
      ch_in[d]    = 2'(ch);
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      if (ch < num_ch(d)) hist_push(d, ch, val);
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk); #1;
         if (data_valid[d]) begin
            lat = n;
            res = out_val(d);
            rch = int'(ch_out[d]);
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (in_ready[0] !== 1'b0) begin
         bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready[0]);
      end
      total++;
      if (data_valid[0] !== 1'b0) begin
         bad++; $display("FAIL reset_valid got=%b want=0", data_valid[0]);
      end
      total++;
      if (data_out[0] !== 8'd0 || ch_out[0] !== 2'd0) begin
         bad++; $display("FAIL reset_outputs got=%0d/%0d want=0/0", data_out[0], ch_out[0]);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      total++;
      if (in_ready[0] !== 1'b1 || in_ready[1] !== 1'b1 || in_ready[2] !== 1'b1) begin
         bad++; $display("FAIL ready_after_reset got=%b%b%b want=111",
                         in_ready[0], in_ready[1], in_ready[2]);
      end
      hist_clear();
   endtask

   task automatic test_constant();
      int exp_tab[6] = '{25, 50, 75, 100, 100, 100};
      int res, rch, lat;
      for (int i = 0; i < 6; i++) begin
         send(0, 0, 100, res, rch, lat);
         total++;
         if (res !== exp_tab[i]) begin
            bad++; $display("FAIL const_data[%0d] got=%0d want=%0d", i, res, exp_tab[i]);
         end
         total++;
         if (rch !== 0) begin
            bad++; $display("FAIL const_ch[%0d] got=%0d want=0", i, rch);
         end
         total++;
         if (lat !== 3) begin
            bad++; $display("FAIL const_latency[%0d] got=%0d want=3", i, lat);
         end
      end
   endtask

   task automatic test_interleave();
      int exp1[4] = '{-10, -20, -30, -40};
      int res, rch, lat;
      for (int i = 0; i < 4; i++) begin
         send(0, 0, 100, res, rch, lat);
         total++;
         if (res !== 100 || rch !== 0) begin
            bad++; $display("FAIL inter_ch0[%0d] got=%0d ch%0d want=100 ch0", i, res, rch);
         end
         send(0, 1, -40, res, rch, lat);
         total++;
         if (res !== exp1[i] || rch !== 1) begin
            bad++; $display("FAIL inter_ch1[%0d] got=%0d ch%0d want=%0d ch1", i, res, rch, exp1[i]);
         end
      end
   endtask

   task automatic test_random();
      int res, rch, lat, ch, val, exp_v;
      for (int i = 0; i < 16; i++) begin
         ch  = int'($urandom_range(0, 1));
         val = int'($urandom_range(0, 255)) - 128;
         send(0, ch, val, res, rch, lat);
         exp_v = model(0, ch);
         total++;
         if (res !== exp_v || rch !== ch || lat !== 3) begin
            bad++; $display("FAIL random[%0d] got=%0d ch%0d lat%0d want=%0d ch%0d lat3",
                            i, res, rch, lat, exp_v, ch);
         end
      end
   endtask

   task automatic test_uint();
      int exp_tab[4] = '{146, 164, 182, 200};
      int res, rch, lat, ch, val, exp_v;
      for (int i = 0; i < 4; i++) begin
         send(1, 0, 200, res, rch, lat);
         total++;
         if (res !== exp_tab[i] || lat !== 3) begin
            bad++; $display("FAIL uint_const[%0d] got=%0d lat%0d want=%0d lat3",
                            i, res, lat, exp_tab[i]);
         end
      end
      for (int i = 0; i < 8; i++) begin
         ch  = int'($urandom_range(0, 1));
         val = int'($urandom_range(0, 255));
         send(1, ch, val, res, rch, lat);
         exp_v = model(1, ch);
         total++;
         if (res !== exp_v || rch !== ch) begin
            bad++; $display("FAIL uint_random[%0d] got=%0d ch%0d want=%0d ch%0d",
                            i, res, rch, exp_v, ch);
         end
      end
   endtask

   task automatic test_saturation();
      int res, rch, lat, ch, val, exp_v;
      for (int i = 0; i < 8; i++) begin
         send(2, 2, -128, res, rch, lat);
         exp_v = model(2, 2);
         total++;
         if (res < -128 || res !== exp_v || rch !== 2) begin
            bad++; $display("FAIL sat_neg[%0d] got=%0d ch%0d want=%0d ch2", i, res, rch, exp_v);
         end
      end
      for (int i = 0; i < 8; i++) begin
         send(2, 1, 127, res, rch, lat);
         exp_v = model(2, 1);
         total++;
         if (res !== exp_v) begin
            bad++; $display("FAIL sat_pos[%0d] got=%0d want=%0d", i, res, exp_v);
         end
      end
      for (int i = 0; i < 10; i++) begin
         ch  = int'($urandom_range(0, 2));
         val = ($urandom_range(0, 1) == 0) ? -128 : 127;
         send(2, ch, val, res, rch, lat);
         exp_v = model(2, ch);
         total++;
         if (res !== exp_v || rch !== ch) begin
            bad++; $display("FAIL sat_mix[%0d] got=%0d ch%0d want=%0d ch%0d",
                            i, res, rch, exp_v, ch);
         end
      end
   endtask

   task automatic test_drop();
      int res, rch, lat, exp_v;
      send(2, 3, 77, res, rch, lat);
      total++;
      if (lat !== -1) begin
         bad++; $display("FAIL drop_no_valid got=lat%0d want=none", lat);
      end
      total++;
      if (in_ready[2] !== 1'b1) begin
         bad++; $display("FAIL drop_ready got=%b want=1", in_ready[2]);
      end
      send(2, 0, 60, res, rch, lat);
      exp_v = model(2, 0);
      total++;
      if (res !== exp_v || rch !== 0 || lat !== 3) begin
         bad++; $display("FAIL drop_next got=%0d ch%0d lat%0d want=%0d ch0 lat3",
                         res, rch, lat, exp_v);
      end
   endtask

   task automatic test_back_to_back();
      int exp_q[$];
      int exp_c[$];
      int accepts, last_out, val, ch, e, ec;
      accepts  = 0;
      last_out = -1;
      val = int'($urandom_range(0, 255)) - 128;
      ch  = int'($urandom_range(0, 1));
      in_valid[0] = 1'b1;
      data_in[0]  = 8'(val);
      ch_in[0]    = 2'(ch);
      for (int c = 0; c < 48; c++) begin
         if (c < 40 && in_ready[0]) begin
            accepts++;
            hist_push(0, ch, val);
            exp_q.push_back(model(0, ch));
            exp_c.push_back(ch);
         end
         @(posedge clk); #1;
         if (c >= 39) in_valid[0] = 1'b0;
         if (data_valid[0]) begin
            e  = (exp_q.size() > 0) ? exp_q.pop_front() : 9999;
            ec = (exp_c.size() > 0) ? exp_c.pop_front() : -1;
            total++;
            if (out_val(0) !== e || int'(ch_out[0]) !== ec) begin
               bad++; $display("FAIL b2b_data[%0d] got=%0d ch%0d want=%0d ch%0d",
                               c, out_val(0), ch_out[0], e, ec);
            end
            if (last_out >= 0) begin
               total++;
               if (c - last_out !== 4) begin
                  bad++; $display("FAIL b2b_spacing[%0d] got=%0d want=4", c, c - last_out);
               end
            end
            last_out = c;
         end
         val = int'($urandom_range(0, 255)) - 128;
         ch  = int'($urandom_range(0, 1));
         data_in[0] = 8'(val);
         ch_in[0]   = 2'(ch);
      end
      total++;
      if (accepts !== 10) begin
         bad++; $display("FAIL b2b_accepts got=%0d want=10", accepts);
      end
      total++;
      if (exp_q.size() !== 0) begin
         bad++; $display("FAIL b2b_lost got=%0d pending want=0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int res, rch, lat, seen;
      seen = 0;
      in_valid[0] = 1'b1;
      data_in[0]  = 8'(90);
      ch_in[0]    = 2'd0;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      total++;
      if (in_ready[0] !== 1'b0) begin
         bad++; $display("FAIL midrst_ready got=%b want=0", in_ready[0]);
      end
      rst = 1'b0;
      for (int n = 0; n < 8; n++) begin
         if (data_valid[0]) seen++;
         @(posedge clk); #1;
      end
      total++;
      if (seen !== 0) begin
         bad++; $display("FAIL midrst_valid got=%0d pulses want=0", seen);
      end
      hist_clear();
      send(0, 0, 100, res, rch, lat);
      total++;
      if (res !== 25 || rch !== 0 || lat !== 3) begin
         bad++; $display("FAIL midrst_restart got=%0d ch%0d lat%0d want=25 ch0 lat3",
                         res, rch, lat);
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = '{1'b0, 1'b0, 1'b0};
      data_in  = '{8'd0, 8'd0, 8'd0};
      ch_in    = '{2'd0, 2'd0, 2'd0};
      test_reset();
      test_constant();
      test_interleave();
      test_random();
      test_uint();
      test_saturation();
      test_drop();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
